// File: rtl/commit_ctrl_pkg.sv
// Shared widths, FSM state encoding and commit-queue entry layout for commit_ctrl.
package commit_ctrl_pkg;

  localparam int unsigned DATA_WID    = 32;
  localparam int unsigned REG_POS_WID = 5;
  localparam int unsigned ROB_POS_WID = 4;

  typedef enum logic {
    COMMIT_ST_RUN   = 1'b0,
    COMMIT_ST_CLEAR = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [REG_POS_WID-1:0] rd;
    logic [DATA_WID-1:0]    val;
    logic [ROB_POS_WID-1:0] rob_pos;
    logic                   mispredict;
  } commit_entry_t;

endpackage

// File: rtl/commit_ctrl_if.sv
// ROB-side retire handshake plus RegFile commit/clear ports of commit_ctrl.
interface commit_ctrl_if;

  logic                                    in_valid;
  logic                                    in_ready;
  logic [commit_ctrl_pkg::REG_POS_WID-1:0] in_rd;
  logic [commit_ctrl_pkg::DATA_WID-1:0]    in_val;
  logic [commit_ctrl_pkg::ROB_POS_WID-1:0] in_rob_pos;
  logic                                    in_mispredict;

  logic                                    commit;
  logic [commit_ctrl_pkg::REG_POS_WID-1:0] commit_rd;
  logic [commit_ctrl_pkg::DATA_WID-1:0]    commit_val;
  logic [commit_ctrl_pkg::ROB_POS_WID-1:0] commit_rob_pos;
  logic                                    flush;
  logic                                    clear;
  logic [commit_ctrl_pkg::REG_POS_WID-1:0] clear_rd;

  modport master (
    output in_valid, in_rd, in_val, in_rob_pos, in_mispredict,
    input  in_ready, commit, commit_rd, commit_val, commit_rob_pos,
    input  flush, clear, clear_rd
  );

  modport slave (
    input  in_valid, in_rd, in_val, in_rob_pos, in_mispredict,
    output in_ready, commit, commit_rd, commit_val, commit_rob_pos,
    output flush, clear, clear_rd
  );

endinterface

// File: rtl/commit_ctrl_fifo.sv
// commit_fifo: register-based in-order queue of retiring entries; flush empties it and wins over push.
module commit_fifo
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  commit_entry_t push_data,
  output logic          full,
  output logic          empty,
  output commit_entry_t head
);

  localparam int unsigned PTR_WID = $clog2(DEPTH);

  commit_entry_t      mem [DEPTH];
  logic [PTR_WID-1:0] wr_ptr;
  logic [PTR_WID-1:0] rd_ptr;
  logic [PTR_WID:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_WID+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_WID'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_WID'(1);
      if (do_push && !do_pop)
        count <= count + (PTR_WID+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (PTR_WID+1)'(1);
    end
  end

endmodule

// File: rtl/commit_ctrl.sv
// Retire sequencer: ROB head -> queue -> RegFile commit, with flush and rename-tag clear walk.
// Optional build macro COMMIT_STATS_EN enables the commit/flush statistics counters.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  commit_ctrl_if.slave        bus,
  output logic                busy,
  output logic [31:0]         stat_commits,
  output logic [31:0]         stat_flushes
);

  commit_state_e          state, state_d;
  commit_entry_t          head, push_data;
  logic                   full, empty, push, pop, fifo_flush;
  logic                   commit_q, commit_d, flush_q, flush_d;
  logic [REG_POS_WID-1:0] commit_rd_q, commit_rd_d, clear_rd_q, clear_rd_d;
  logic [DATA_WID-1:0]    commit_val_q, commit_val_d;
  logic [ROB_POS_WID-1:0] commit_rob_pos_q, commit_rob_pos_d;

  assign bus.in_ready = (state == COMMIT_ST_RUN) && !full;
  assign push         = rdy && bus.in_valid && bus.in_ready;
  assign pop          = rdy && (state == COMMIT_ST_RUN) && !empty;
  // A mispredict pop also drops anything pushed on the same edge.
  assign fifo_flush   = pop && head.mispredict;
  assign push_data    = '{rd: bus.in_rd, val: bus.in_val, rob_pos: bus.in_rob_pos,
                          mispredict: bus.in_mispredict};

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (fifo_flush),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_comb begin
    state_d          = state;
    commit_d         = 1'b0;
    flush_d          = 1'b0;
    commit_rd_d      = commit_rd_q;
    commit_val_d     = commit_val_q;
    commit_rob_pos_d = commit_rob_pos_q;
    clear_rd_d       = clear_rd_q;
    case (state)
      COMMIT_ST_RUN: begin
        if (!empty) begin
          commit_d         = 1'b1;
          commit_rd_d      = head.rd;
          commit_val_d     = head.val;
          commit_rob_pos_d = head.rob_pos;
          if (head.mispredict) begin
            flush_d    = 1'b1;
            state_d    = COMMIT_ST_CLEAR;
            clear_rd_d = REG_POS_WID'(1);
          end
        end
      end
      COMMIT_ST_CLEAR: begin
        if (clear_rd_q == REG_POS_WID'(NREG - 1))
          state_d = COMMIT_ST_RUN;
        else
          clear_rd_d = clear_rd_q + REG_POS_WID'(1);
      end
      default: state_d = COMMIT_ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= COMMIT_ST_RUN;
      commit_q         <= 1'b0;
      flush_q          <= 1'b0;
      commit_rd_q      <= '0;
      commit_val_q     <= '0;
      commit_rob_pos_q <= '0;
      clear_rd_q       <= '0;
    end else if (rdy) begin
      state            <= state_d;
      commit_q         <= commit_d;
      flush_q          <= flush_d;
      commit_rd_q      <= commit_rd_d;
      commit_val_q     <= commit_val_d;
      commit_rob_pos_q <= commit_rob_pos_d;
      clear_rd_q       <= clear_rd_d;
    end
  end

  assign bus.commit         = commit_q;
  assign bus.commit_rd      = commit_rd_q;
  assign bus.commit_val     = commit_val_q;
  assign bus.commit_rob_pos = commit_rob_pos_q;
  assign bus.flush          = flush_q;
  assign bus.clear          = (state == COMMIT_ST_CLEAR);
  assign bus.clear_rd       = clear_rd_q;
  assign busy               = (state == COMMIT_ST_CLEAR);

`ifdef COMMIT_STATS_EN
  logic [31:0] commits_q, flushes_q;

  // A pulse is counted on the edge that consumes it, so a rdy=0 hold counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      commits_q <= '0;
      flushes_q <= '0;
    end else if (rdy) begin
      if (commit_q) commits_q <= commits_q + 32'd1;
      if (flush_q)  flushes_q <= flushes_q + 32'd1;
    end
  end

  assign stat_commits = commits_q;
  assign stat_flushes = flushes_q;
`else
  assign stat_commits = '0;
  assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl: vector table, directed corner sequences, random vs queue model.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        busy;
  logic [31:0] stat_commits;
  logic [31:0] stat_flushes;

  commit_ctrl_if bus();

  commit_ctrl #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .bus          (bus),
    .busy         (busy),
    .stat_commits (stat_commits),
    .stat_flushes (stat_flushes)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of pending entries plus a countdown of clear cycles.
  commit_entry_t mq[$];
  bit            m_commit, m_flush;
  logic [4:0]    m_rd;
  logic [31:0]   m_val;
  logic [3:0]    m_rp;
  int            m_left;
  int            m_clear_rd;
  int unsigned   m_sc, m_sf;

  task automatic model_edge();
    commit_entry_t e;
    bit acc;
    if (rst) begin
      mq.delete();
      m_commit = 0; m_flush = 0; m_rd = '0; m_val = '0; m_rp = '0;
      m_left = 0; m_clear_rd = 0; m_sc = 0; m_sf = 0;
    end else if (rdy) begin
      acc = bus.in_valid && (m_left == 0) && (mq.size() < DEPTH);
      if (m_commit) m_sc++;
      if (m_flush)  m_sf++;
      m_commit = 0;
      m_flush  = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left > 0) m_clear_rd++;
      end else begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_commit = 1; m_rd = e.rd; m_val = e.val; m_rp = e.rob_pos;
          if (e.mispredict) begin
            m_flush = 1;
            mq.delete();
            acc = 0;
            m_left = NREG - 1;
            m_clear_rd = 1;
          end
        end
        if (acc)
          mq.push_back('{rd: bus.in_rd, val: bus.in_val, rob_pos: bus.in_rob_pos,
                         mispredict: bus.in_mispredict});
      end
    end
  endtask

  task automatic check_model();
    chk("m_in_ready", bus.in_ready, (m_left == 0) && (mq.size() < DEPTH));
    chk("m_commit", bus.commit, m_commit);
    if (m_commit) begin
      chk("m_commit_rd", bus.commit_rd, m_rd);
      chk("m_commit_val", bus.commit_val, m_val);
      chk("m_commit_rob_pos", bus.commit_rob_pos, m_rp);
    end
    chk("m_flush", bus.flush, m_flush);
    chk("m_clear", bus.clear, m_left > 0);
    if (m_left > 0) chk("m_clear_rd", bus.clear_rd, m_clear_rd);
    chk("m_busy", busy, m_left > 0);
`ifdef COMMIT_STATS_EN
    chk("m_stat_commits", stat_commits, m_sc);
    chk("m_stat_flushes", stat_flushes, m_sf);
`else
    chk("m_stat_commits", stat_commits, 0);
    chk("m_stat_flushes", stat_flushes, 0);
`endif
  endtask

  task automatic cyc(input bit r, input bit en, input bit v, input logic [4:0] rd,
                     input logic [31:0] val, input logic [3:0] rp, input bit mp);
    rst = r; rdy = en;
    bus.in_valid = v; bus.in_rd = rd; bus.in_val = val;
    bus.in_rob_pos = rp; bus.in_mispredict = mp;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input bit en);
    cyc(1'b0, en, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
  endtask

  typedef struct {
    bit          rdy;
    bit          v;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  rp;
    bit          e_commit;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [3:0]  e_rp;
    bit          e_ready;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int acc_n;
    int ncommit;
    int got[$];
    bit will;

    tbl[0] = '{1, 1, 5'd5, 32'hDEADBEEF, 4'd3, 0, 5'd0, 32'h0,        4'd0, 1};
    tbl[1] = '{1, 0, 5'd0, 32'h0,        4'd0, 1, 5'd5, 32'hDEADBEEF, 4'd3, 1};
    tbl[2] = '{1, 0, 5'd0, 32'h0,        4'd0, 0, 5'd0, 32'h0,        4'd0, 1};
    tbl[3] = '{1, 1, 5'd7, 32'h1234,     4'd1, 0, 5'd0, 32'h0,        4'd0, 1};
    tbl[4] = '{1, 0, 5'd0, 32'h0,        4'd0, 1, 5'd7, 32'h1234,     4'd1, 1};
    tbl[5] = '{0, 0, 5'd0, 32'h0,        4'd0, 1, 5'd7, 32'h1234,     4'd1, 1};
    tbl[6] = '{0, 0, 5'd0, 32'h0,        4'd0, 1, 5'd7, 32'h1234,     4'd1, 1};
    tbl[7] = '{0, 0, 5'd0, 32'h0,        4'd0, 1, 5'd7, 32'h1234,     4'd1, 1};
    tbl[8] = '{1, 0, 5'd0, 32'h0,        4'd0, 0, 5'd0, 32'h0,        4'd0, 1};

    rst = 1'b1; rdy = 1'b1;
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_val = '0;
    bus.in_rob_pos = '0; bus.in_mispredict = 1'b0;

    cyc(1, 1, 0, 5'd0, 32'd0, 4'd0, 0);
    cyc(1, 1, 0, 5'd0, 32'd0, 4'd0, 0);
    chk("rst_commit", bus.commit, 0);
    chk("rst_commit_rd", bus.commit_rd, 0);
    chk("rst_commit_val", bus.commit_val, 0);
    chk("rst_commit_rob_pos", bus.commit_rob_pos, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_clear", bus.clear, 0);
    chk("rst_clear_rd", bus.clear_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_stat_commits", stat_commits, 0);

    // Single entry latency and rdy=0 hold of a pending commit
    for (int i = 0; i < 9; i++) begin
      cyc(0, tbl[i].rdy, tbl[i].v, tbl[i].rd, tbl[i].val, tbl[i].rp, 0);
      chk("tbl_commit", bus.commit, tbl[i].e_commit);
      chk("tbl_in_ready", bus.in_ready, tbl[i].e_ready);
      if (tbl[i].e_commit) begin
        chk("tbl_commit_rd", bus.commit_rd, tbl[i].e_rd);
        chk("tbl_commit_val", bus.commit_val, tbl[i].e_val);
        chk("tbl_commit_rob_pos", bus.commit_rob_pos, tbl[i].e_rp);
      end
    end

    // Burst of six back-to-back entries
    acc_n = 0;
    for (int i = 0; i < 40 && (acc_n < 6 || got.size() < 6); i++) begin
      will = (acc_n < 6) && bus.in_ready;
      cyc(0, 1, acc_n < 6, 5'(10 + acc_n), 32'(256 + acc_n), 4'(acc_n), 0);
      if (will) acc_n++;
      if (bus.commit) got.push_back(int'(bus.commit_rd));
    end
    chk("burst_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("burst_order", (i < got.size()) ? got[i] : -1, 10 + i);

    // Mispredict head with younger entries arriving behind it
    idle(1);
    cyc(0, 1, 1, 5'd3, 32'hA5A5A5A5, 4'd7, 1);
    cyc(0, 1, 1, 5'd4, 32'h0000000B, 4'd8, 0);
    chk("mp_commit", bus.commit, 1);
    chk("mp_commit_rd", bus.commit_rd, 3);
    chk("mp_flush", bus.flush, 1);
    chk("mp_clear_rd", bus.clear_rd, 1);
    chk("mp_in_ready", bus.in_ready, 0);
    ncommit = 0;
    for (int i = 2; i <= 31; i++) begin
      cyc(0, 1, 1, 5'd6, 32'h0000000C, 4'd9, 0);
      chk("walk_clear_rd", bus.clear_rd, i);
      chk("walk_busy", busy, 1);
      if (bus.commit) ncommit++;
    end
    idle(1);
    chk("walk_done_busy", busy, 0);
    chk("walk_done_clear", bus.clear, 0);
    chk("walk_done_in_ready", bus.in_ready, 1);
    idle(1);
    if (bus.commit) ncommit++;
    chk("younger_commits", ncommit, 0);

    // Reset in the middle of the clear walk
    cyc(0, 1, 1, 5'd9, 32'h99, 4'd2, 1);
    idle(1);
    for (int i = 0; i < 40 && bus.clear_rd != 5'd10; i++) idle(1);
    chk("rst_walk_reach", bus.clear_rd, 10);
    cyc(1, 1, 0, 5'd0, 32'd0, 4'd0, 0);
    chk("midrst_clear", bus.clear, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    idle(1);
    chk("midrst_commit", bus.commit, 0);

    // Statistics: 7 commits, one of them mispredicted
    cyc(1, 1, 0, 5'd0, 32'd0, 4'd0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 5'(i + 1), 32'(i), 4'(i), 0);
    cyc(0, 1, 1, 5'd20, 32'h77, 4'd6, 1);
    for (int i = 0; i < 36; i++) idle(1);
`ifdef COMMIT_STATS_EN
    chk("stat_commits_7", stat_commits, 7);
    chk("stat_flushes_1", stat_flushes, 1);
`else
    chk("stat_commits_off", stat_commits, 0);
    chk("stat_flushes_off", stat_flushes, 0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 9) < 6, 5'($urandom), $urandom, 4'($urandom),
          $urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
